centroid_acc: RTL and testbench

Streaming centroid accumulator for the trilateration datapath. It collects a batch of up to K signed (x, y) points over a valid/ready handshake and sums each axis. Optionally it divides each sum by the point count with a sequential restoring divider, producing the centroid. It generalises the fixed three-point combinational sum to a parametrised batch size, early batch close, backpressure and an optional mean output.

---
 rtl/centroid_acc.sv | 219 +++++++++++++++++++++
 tb/tb_centroid_acc.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/centroid_acc.sv
// centroid_acc: streaming batch accumulator for (x, y) points.
// Sums up to K signed points per batch, and with DIV_EN=1 also divides each
// sum by the point count with a bit-serial restoring divider to give the mean.
module centroid_acc #(
    parameter int N      = 8,
    parameter int K      = 3,
    parameter int DIV_EN = 1,
    localparam int DW    = N + 2,
    localparam int CW    = $clog2(K + 1),
    localparam int SW    = N + 2 + $clog2(K)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_x,
    input  logic signed [DW-1:0] in_y,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [SW-1:0] out_sx,
    output logic signed [SW-1:0] out_sy,
    output logic signed [DW-1:0] out_mx,
    output logic signed [DW-1:0] out_my,
    output logic        [CW-1:0] out_cnt
);

    localparam int ITW = $clog2(SW + 1);

    typedef enum logic [1:0] {
        ST_ACC = 2'd0,
        ST_DIV = 2'd1,
        ST_OUT = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  in_ready_q, in_ready_d;
    logic signed [SW-1:0]  sx_q, sx_d;
    logic signed [SW-1:0]  sy_q, sy_d;
    logic        [CW-1:0]  cnt_q, cnt_d;
    // Divider: a_* starts as |sum| and shifts into the quotient, r_* is the remainder.
    logic        [SW-1:0]  ax_q, ax_d;
    logic        [SW-1:0]  ay_q, ay_d;
    logic        [CW-1:0]  rx_q, rx_d;
    logic        [CW-1:0]  ry_q, ry_d;
    logic                  neg_x_q, neg_x_d;
    logic                  neg_y_q, neg_y_d;
    logic        [ITW-1:0] it_q, it_d;
    logic signed [SW-1:0]  out_sx_q, out_sx_d;
    logic signed [SW-1:0]  out_sy_q, out_sy_d;
    logic signed [DW-1:0]  out_mx_q, out_mx_d;
    logic signed [DW-1:0]  out_my_q, out_my_d;
    logic        [CW-1:0]  out_cnt_q, out_cnt_d;

    logic                  accept;
    logic                  close;
    logic     [CW+SW-1:0]  step_x;
    logic     [CW+SW-1:0]  step_y;

    function automatic logic signed [SW-1:0] sext(input logic signed [DW-1:0] v);
        return {{(SW-DW){v[DW-1]}}, v};
    endfunction

    function automatic logic [SW-1:0] abs_val(input logic signed [SW-1:0] v);
        logic [SW-1:0] u;
        u = v;
        return v[SW-1] ? (~u) + SW'(1) : u;
    endfunction

    // Restores the sum's sign onto the magnitude quotient (truncation toward zero).
    function automatic logic signed [DW-1:0] apply_sign(input logic [SW-1:0] q, input logic neg);
        logic [SW-1:0] t;
        t = neg ? (~q) + SW'(1) : q;
        return t[DW-1:0];
    endfunction

    // One restoring-division iteration; returns {remainder, shifted dividend/quotient}.
    function automatic logic [CW+SW-1:0] div_step(input logic [SW-1:0] a,
                                                  input logic [CW-1:0] r,
                                                  input logic [CW-1:0] d);
        logic [CW:0]   sh;
        logic [CW:0]   diff;
        logic          qb;
        logic [CW-1:0] rn;
        sh   = {r, a[SW-1]};
        diff = sh - {1'b0, d};
        qb   = (sh >= {1'b0, d});
        rn   = qb ? diff[CW-1:0] : sh[CW-1:0];
        return {rn, a[SW-2:0], qb};
    endfunction

    // Next-state, accumulation, divider step and result capture.
    always_comb begin
        state_d    = state_q;
        in_ready_d = in_ready_q;
        sx_d       = sx_q;
        sy_d       = sy_q;
        cnt_d      = cnt_q;
        ax_d       = ax_q;
        ay_d       = ay_q;
        rx_d       = rx_q;
        ry_d       = ry_q;
        neg_x_d    = neg_x_q;
        neg_y_d    = neg_y_q;
        it_d       = it_q;
        out_sx_d   = out_sx_q;
        out_sy_d   = out_sy_q;
        out_mx_d   = out_mx_q;
        out_my_d   = out_my_q;
        out_cnt_d  = out_cnt_q;
        accept     = 1'b0;
        close      = 1'b0;
        step_x     = div_step(ax_q, rx_q, cnt_q);
        step_y     = div_step(ay_q, ry_q, cnt_q);

        case (state_q)
            ST_ACC: begin
                in_ready_d = 1'b1;
                accept     = in_valid && in_ready_q;
                if (accept) begin
                    sx_d  = sx_q + sext(in_x);
                    sy_d  = sy_q + sext(in_y);
                    cnt_d = cnt_q + CW'(1);
                end
                close = (accept && (cnt_q == CW'(K - 1))) || (flush && (cnt_d != '0));
                if (close) begin
                    in_ready_d = 1'b0;
                    out_sx_d   = sx_d;
                    out_sy_d   = sy_d;
                    out_cnt_d  = cnt_d;
                    out_mx_d   = '0;
                    out_my_d   = '0;
                    ax_d       = abs_val(sx_d);
                    ay_d       = abs_val(sy_d);
                    neg_x_d    = sx_d[SW-1];
                    neg_y_d    = sy_d[SW-1];
                    rx_d       = '0;
                    ry_d       = '0;
                    it_d       = '0;
                    state_d    = (DIV_EN != 0) ? ST_DIV : ST_OUT;
                end
            end
            ST_DIV: begin
                ax_d = step_x[SW-1:0];
                rx_d = step_x[CW+SW-1:SW];
                ay_d = step_y[SW-1:0];
                ry_d = step_y[CW+SW-1:SW];
                it_d = it_q + ITW'(1);
                if (it_q == ITW'(SW - 1)) begin
                    state_d  = ST_OUT;
                    out_mx_d = apply_sign(step_x[SW-1:0], neg_x_q);
                    out_my_d = apply_sign(step_y[SW-1:0], neg_y_q);
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d    = ST_ACC;
                    in_ready_d = 1'b1;
                    sx_d       = '0;
                    sy_d       = '0;
                    cnt_d      = '0;
                end
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase
    end

    // State and datapath registers; reset discards any batch in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ACC;
            in_ready_q <= 1'b0;
            sx_q       <= '0;
            sy_q       <= '0;
            cnt_q      <= '0;
            ax_q       <= '0;
            ay_q       <= '0;
            rx_q       <= '0;
            ry_q       <= '0;
            neg_x_q    <= 1'b0;
            neg_y_q    <= 1'b0;
            it_q       <= '0;
            out_sx_q   <= '0;
            out_sy_q   <= '0;
            out_mx_q   <= '0;
            out_my_q   <= '0;
            out_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            sx_q       <= sx_d;
            sy_q       <= sy_d;
            cnt_q      <= cnt_d;
            ax_q       <= ax_d;
            ay_q       <= ay_d;
            rx_q       <= rx_d;
            ry_q       <= ry_d;
            neg_x_q    <= neg_x_d;
            neg_y_q    <= neg_y_d;
            it_q       <= it_d;
            out_sx_q   <= out_sx_d;
            out_sy_q   <= out_sy_d;
            out_mx_q   <= out_mx_d;
            out_my_q   <= out_my_d;
            out_cnt_q  <= out_cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q == ST_OUT);
    assign out_sx    = out_sx_q;
    assign out_sy    = out_sy_q;
    assign out_mx    = out_mx_q;
    assign out_my    = out_my_q;
    assign out_cnt   = out_cnt_q;

endmodule

// File: tb/tb_centroid_acc.sv
// Bench for centroid_acc: a dividing K=3 instance and a sum-only K=4 instance.
module tb_centroid_acc;

    localparam int N   = 8;
    localparam int DW  = N + 2;
    localparam int KA  = 3;
    localparam int KB  = 4;
    localparam int SWA = N + 2 + $clog2(KA);
    localparam int SWB = N + 2 + $clog2(KB);
    localparam int CWA = $clog2(KA + 1);
    localparam int CWB = $clog2(KB + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic                  in_valid, in_ready, flush, out_valid, out_ready;
    logic signed [DW-1:0]  in_x, in_y, out_mx, out_my;
    logic signed [SWA-1:0] out_sx, out_sy;
    logic        [CWA-1:0] out_cnt;

    logic                  b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
    logic signed [DW-1:0]  b_in_x, b_in_y, b_out_mx, b_out_my;
    logic signed [SWB-1:0] b_out_sx, b_out_sy;
    logic        [CWB-1:0] b_out_cnt;

    centroid_acc #(.N(N), .K(KA), .DIV_EN(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_sx(out_sx), .out_sy(out_sy), .out_mx(out_mx), .out_my(out_my),
        .out_cnt(out_cnt)
    );

    centroid_acc #(.N(N), .K(KB), .DIV_EN(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_x(b_in_x), .in_y(b_in_y),
        .flush(b_flush), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_sx(b_out_sx), .out_sy(b_out_sy), .out_mx(b_out_mx), .out_my(b_out_my),
        .out_cnt(b_out_cnt)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int px[16];
    int py[16];

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input int x, input int y, input bit fl);
        int w;
        w = 0;
        repeat ($urandom_range(0, 1)) tick();
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        chk("a_in_ready_before_point", in_ready, 1);
        in_valid = 1'b1;
        in_x     = DW'(x);
        in_y     = DW'(y);
        flush    = fl;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    // Reference: plain integer sums and C-style (toward-zero) division.
    task automatic batch_a(input int n, input bit fl, input int hold);
        int esx, esy, lat;
        esx = 0;
        esy = 0;
        lat = 0;
        for (int i = 0; i < n; i++) begin
            esx += px[i];
            esy += py[i];
        end
        out_ready = (hold == 0);
        for (int i = 0; i < n; i++) send_a(px[i], py[i], fl && (i == n - 1));
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        chk("a_latency", lat, SWA);
        chk("a_out_sx", out_sx, esx);
        chk("a_out_sy", out_sy, esy);
        chk("a_out_mx", out_mx, esx / n);
        chk("a_out_my", out_my, esy / n);
        chk("a_out_cnt", out_cnt, n);
        chk("a_in_ready_in_out", in_ready, 0);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_x     = DW'($urandom);
            in_y     = DW'($urandom);
            tick();
            chk("a_hold_valid", out_valid, 1);
            chk("a_hold_sx", out_sx, esx);
            chk("a_hold_my", out_my, esy / n);
            chk("a_hold_cnt", out_cnt, n);
            chk("a_hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("a_after_hs_valid", out_valid, 0);
        chk("a_after_hs_in_ready", in_ready, 1);
    endtask

    task automatic send_b(input int x, input int y, input bit fl);
        int w;
        w = 0;
        while (!b_in_ready && w < 50) begin
            tick();
            w++;
        end
        chk("b_in_ready_before_point", b_in_ready, 1);
        b_in_valid = 1'b1;
        b_in_x     = DW'(x);
        b_in_y     = DW'(y);
        b_flush    = fl;
        tick();
        b_in_valid = 1'b0;
        b_flush    = 1'b0;
    endtask

    task automatic batch_b(input int n, input bit fl);
        int esx, esy;
        esx = 0;
        esy = 0;
        for (int i = 0; i < n; i++) begin
            esx += px[i];
            esy += py[i];
        end
        for (int i = 0; i < n; i++) send_b(px[i], py[i], fl && (i == n - 1));
        chk("b_valid_after_close", b_out_valid, 1);
        chk("b_out_sx", b_out_sx, esx);
        chk("b_out_sy", b_out_sy, esy);
        chk("b_out_mx", b_out_mx, 0);
        chk("b_out_my", b_out_my, 0);
        chk("b_out_cnt", b_out_cnt, n);
        tick();
        chk("b_after_hs_valid", b_out_valid, 0);
        chk("b_after_hs_in_ready", b_in_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit fl;

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_x        = '0;
        in_y        = '0;
        flush       = 1'b0;
        out_ready   = 1'b1;
        b_in_valid  = 1'b0;
        b_in_x      = '0;
        b_in_y      = '0;
        b_flush     = 1'b0;
        b_out_ready = 1'b1;

        // Reset state
        repeat (3) tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sx", out_sx, 0);
        chk("rst_out_mx", out_mx, 0);
        chk("rst_out_cnt", out_cnt, 0);
        chk("rst_b_in_ready", b_in_ready, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_release_in_ready_low", in_ready, 0);
        tick();
        chk("rst_first_edge_in_ready", in_ready, 1);
        chk("rst_first_edge_b_in_ready", b_in_ready, 1);

        // Full batch with division
        px[0] = 10; py[0] = -4;
        px[1] = 20; py[1] = 5;
        px[2] = 31; py[2] = -9;
        batch_a(3, 1'b0, 0);

        // Flush with an empty batch does nothing
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("empty_flush_valid", out_valid, 0);
        chk("empty_flush_in_ready", in_ready, 1);
        tick();
        chk("empty_flush_valid2", out_valid, 0);

        // Partial batch closed by flush on the last accept
        px[0] = -7; py[0] = 7;
        px[1] = -8; py[1] = 8;
        batch_a(2, 1'b1, 0);

        // Backpressure, then a fresh batch must start from zero
        px[0] = 100;  py[0] = -300;
        px[1] = -45;  py[1] = 17;
        px[2] = 7;    py[2] = 2;
        batch_a(3, 1'b0, 5);
        px[0] = 10; py[0] = -4;
        px[1] = 20; py[1] = 5;
        px[2] = 31; py[2] = -9;
        batch_a(3, 1'b0, 0);

        // Extremes
        for (int i = 0; i < 3; i++) begin
            px[i] = -512;
            py[i] = 511;
        end
        batch_a(3, 1'b0, 0);
        px[0] = -1; py[0] = 1;
        px[1] = -2; py[1] = 2;
        px[2] = -2; py[2] = 2;
        batch_a(3, 1'b0, 0);

        // Reset while dividing
        px[0] = 10; py[0] = -4;
        px[1] = 20; py[1] = 5;
        px[2] = 31; py[2] = -9;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send_a(px[i], py[i], 1'b0);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk("mid_div_rst_out_valid", out_valid, 0);
        chk("mid_div_rst_in_ready", in_ready, 0);
        chk("mid_div_rst_out_cnt", out_cnt, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("mid_div_release_in_ready", in_ready, 1);
        batch_a(3, 1'b0, 0);

        // Sum-only instance
        for (int i = 0; i < 4; i++) begin
            px[i] = i + 1;
            py[i] = -(i + 1);
        end
        batch_b(4, 1'b0);
        px[0] = 300; py[0] = -512;
        px[1] = -9;  py[1] = 511;
        batch_b(2, 1'b1);

        // Randomized batches against the reference
        for (int t = 0; t < 20; t++) begin
            n  = $urandom_range(1, KA);
            fl = (n < KA) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++) begin
                px[i] = int'($urandom_range(0, 1023)) - 512;
                py[i] = int'($urandom_range(0, 1023)) - 512;
            end
            batch_a(n, fl, $urandom_range(0, 3));
        end
        for (int t = 0; t < 8; t++) begin
            n  = $urandom_range(1, KB);
            fl = (n < KB) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++) begin
                px[i] = int'($urandom_range(0, 1023)) - 512;
                py[i] = int'($urandom_range(0, 1023)) - 512;
            end
            batch_b(n, fl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
